// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the fabric reset sequencer.
// Optional feature macro used by the sequencer: RESET_SEQ_SWREQ_EN.
package reset_seq_pkg;

   localparam int unsigned MAX_CH = 16;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      WAIT = 2'd1,
      RUN  = 2'd2
   } seq_state_t;

   // The counter must reach both the init hold count and the timeout count without wrapping.
   function automatic int unsigned CNT_W(input int unsigned init_cycles,
                                         input int unsigned timeout_cycles);
      int unsigned m;
      m = (init_cycles > timeout_cycles) ? init_cycles : timeout_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Channel-side bundle of the reset sequencer: ready inputs, released resets and status.
// sw_rst_req exists only when RESET_SEQ_SWREQ_EN is defined.
interface reset_sequencer_if #(
   parameter int unsigned N_CH = 4
);
   logic [N_CH-1:0] ch_ready;
`ifdef RESET_SEQ_SWREQ_EN
   logic            sw_rst_req;
`endif
   logic [N_CH-1:0] rst_n_o;
   logic            seq_done;
   logic [N_CH-1:0] timeout_err;
   logic [3:0]      cur_ch;

`ifdef RESET_SEQ_SWREQ_EN
   modport master (
      input  ch_ready,
      input  sw_rst_req,
      output rst_n_o,
      output seq_done,
      output timeout_err,
      output cur_ch
   );

   modport slave (
      output ch_ready,
      output sw_rst_req,
      input  rst_n_o,
      input  seq_done,
      input  timeout_err,
      input  cur_ch
   );
`else
   modport master (
      input  ch_ready,
      output rst_n_o,
      output seq_done,
      output timeout_err,
      output cur_ch
   );

   modport slave (
      output ch_ready,
      input  rst_n_o,
      input  seq_done,
      input  timeout_err,
      input  cur_ch
   );
`endif

endinterface

// File: rtl/reset_sequencer_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clock edge.
module reset_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_rst_n
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= 1'b1;
         r_sync <= r_meta;
      end
   end

   assign o_rst_n = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Fabric reset sequencer: synchronises NSYSRESET, holds, then releases N_CH domains in order.
// Define RESET_SEQ_SWREQ_EN to add the software resequence request (sw_rst_req).
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned N_CH           = 4,
   parameter int unsigned INIT_CYCLES    = 10,
   parameter int unsigned STEP_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic               SYSCLK,
   input  logic               NSYSRESET,
   reset_sequencer_if.master  seq_if
);

   localparam int unsigned    CW          = CNT_W(INIT_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  C_ONE       = CW'(1);
   localparam logic [CW-1:0]  C_INIT_LAST = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0]  C_STEP      = CW'(STEP_CYCLES);
   localparam logic [CW-1:0]  C_TMO       = CW'(TIMEOUT_CYCLES);
   localparam logic [3:0]     C_LAST_CH   = 4'(N_CH - 1);

   logic              w_rst_n_sync;
   logic              w_swreq;

   seq_state_t        r_state;
   logic [CW-1:0]     r_cnt;
   logic [N_CH-1:0]   r_rst_n;
   logic              r_done;
   logic [N_CH-1:0]   r_err;
   logic [3:0]        r_cur;

   seq_state_t        w_state_nxt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [N_CH-1:0]   w_rst_n_nxt;
   logic              w_done_nxt;
   logic [N_CH-1:0]   w_err_nxt;
   logic [3:0]        w_cur_nxt;

   logic              w_ready_sel;
   logic              w_ack;
   logic              w_tmo;

   reset_sync u_sync (
      .i_clk   (SYSCLK),
      .i_rst_n (NSYSRESET),
      .o_rst_n (w_rst_n_sync)
   );

`ifdef RESET_SEQ_SWREQ_EN
   assign w_swreq = seq_if.sw_rst_req;
`else
   assign w_swreq = 1'b0;
`endif

   always_comb begin
      w_ready_sel = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (r_cur == 4'(i)) begin
            w_ready_sel = seq_if.ch_ready[i];
         end
      end
   end

   // A ready seen before the step spacing has elapsed is simply sampled again next cycle.
   assign w_ack = (r_cnt >= C_STEP) && w_ready_sel;
   assign w_tmo = (r_cnt == C_TMO);

   always_ff @(posedge SYSCLK or negedge w_rst_n_sync) begin
      if (!w_rst_n_sync) begin
         r_state <= HOLD;
         r_cnt   <= '0;
         r_rst_n <= '0;
         r_done  <= 1'b0;
         r_err   <= '0;
         r_cur   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rst_n <= w_rst_n_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_cur   <= w_cur_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rst_n_nxt = r_rst_n;
      w_done_nxt  = r_done;
      w_err_nxt   = r_err;
      w_cur_nxt   = r_cur;

      unique case (r_state)
         HOLD: begin
            if (r_cnt == C_INIT_LAST) begin
               w_rst_n_nxt[0] = 1'b1;
               w_cnt_nxt      = C_ONE;
               w_state_nxt    = WAIT;
            end else begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end

         WAIT: begin
            if (w_ack || w_tmo) begin
               // A ready landing exactly on the timeout cycle counts as an acknowledge.
               if (!w_ack) begin
                  for (int unsigned i = 0; i < N_CH; i++) begin
                     if (r_cur == 4'(i)) begin
                        w_err_nxt[i] = 1'b1;
                     end
                  end
               end
               if (r_cur == C_LAST_CH) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  for (int unsigned i = 1; i < N_CH; i++) begin
                     if (r_cur == 4'(i - 1)) begin
                        w_rst_n_nxt[i] = 1'b1;
                     end
                  end
                  w_cur_nxt = r_cur + 4'd1;
                  w_cnt_nxt = C_ONE;
               end
            end else if (!w_tmo) begin
               w_cnt_nxt = r_cnt + C_ONE;
            end
         end

         RUN: begin
         end

         default: begin
            w_state_nxt = HOLD;
         end
      endcase

      if (w_swreq) begin
         w_state_nxt = HOLD;
         w_cnt_nxt   = '0;
         w_rst_n_nxt = '0;
         w_done_nxt  = 1'b0;
         w_err_nxt   = '0;
         w_cur_nxt   = '0;
      end
   end

   assign seq_if.rst_n_o     = r_rst_n;
   assign seq_if.seq_done    = r_done;
   assign seq_if.timeout_err = r_err;
   assign seq_if.cur_ch      = r_cur;

   // Released resets only ever drop through a full reset or a software request.
   a_monotonic: assert property (@(posedge SYSCLK) disable iff (!w_rst_n_sync)
      ((r_rst_n & ~w_rst_n_nxt) == '0) || w_swreq);

   a_thermometer: assert property (@(posedge SYSCLK) disable iff (!w_rst_n_sync)
      ((r_rst_n + N_CH'(1)) & r_rst_n) == '0);

   a_done_all: assert property (@(posedge SYSCLK) disable iff (!w_rst_n_sync)
      r_done |-> (&r_rst_n));

   a_err_released: assert property (@(posedge SYSCLK) disable iff (!w_rst_n_sync)
      (r_err & ~r_rst_n) == '0);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: release-time model per channel, randomised ready arrival.
// Software resequence scenarios are included when RESET_SEQ_SWREQ_EN is defined.
module tb_reset_sequencer;

   localparam int N     = 4;
   localparam int INIT  = 10;
   localparam int STEP  = 4;
   localparam int TMO   = 32;
   localparam int NEVER = 1000000;

   logic SYSCLK    = 1'b0;
   logic NSYSRESET = 1'b1;

   reset_sequencer_if #(.N_CH(N)) sif ();

   reset_sequencer #(
      .N_CH           (N),
      .INIT_CYCLES    (INIT),
      .STEP_CYCLES    (STEP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .SYSCLK    (SYSCLK),
      .NSYSRESET (NSYSRESET),
      .seq_if    (sif)
   );

   always #50 SYSCLK = ~SYSCLK;

   int checks = 0;
   int errors = 0;

   int ecount;          // rising edges since NSYSRESET release (or since a resequence base)
   int base;            // edge after which the sequencer sits at the start of its hold
   int rdy_edge [N];    // first edge at which ch_ready[k] is sampled high
   bit noise;           // scramble ch_ready once the sequence has completed
   int rel [N+1];       // edge at which channel k releases; rel[N] is the done edge
   bit tmo [N];

   logic [2*N+4:0] obs;
   assign obs = {sif.rst_n_o, sif.seq_done, sif.timeout_err, sif.cur_ch};

   // Channel k is released at t_k; it is acknowledged at the first edge that is both
   // at least STEP after t_k and has ready sampled, unless that lies beyond t_k+TMO.
   function automatic void plan();
      int t;
      int want;
      t = base + INIT;
      for (int k = 0; k < N; k++) begin
         rel[k] = t;
         want   = (rdy_edge[k] > t + STEP) ? rdy_edge[k] : t + STEP;
         tmo[k] = (want > t + TMO);
         t      = tmo[k] ? t + TMO : want;
      end
      rel[N] = t;
   endfunction

   function automatic logic [2*N+4:0] exp_vec(input int e);
      logic [N-1:0] r;
      logic [N-1:0] er;
      logic [3:0]   c;
      c = 4'd0;
      for (int k = 0; k < N; k++) begin
         r[k]  = (e >= rel[k]);
         er[k] = tmo[k] && (e >= rel[k+1]);
         if (k > 0 && e >= rel[k]) c = 4'(k);
      end
      return {r, logic'(e >= rel[N]), er, c};
   endfunction

   task automatic tick();
      int e;
      e = ecount + 1;
      for (int k = 0; k < N; k++) begin
         if (noise && e > rel[N] + 1) sif.ch_ready[k] = 1'($urandom_range(0, 1));
         else                         sif.ch_ready[k] = (e >= rdy_edge[k]);
      end
      @(posedge SYSCLK);
      ecount++;
      #10;
   endtask

   task automatic hold_reset();
      NSYSRESET = 1'b0;
      noise     = 1'b0;
      base      = NEVER;
      plan();
      repeat (2) tick();
   endtask

   task automatic start_seq();
      ecount    = 0;
      base      = 2;
      plan();
      NSYSRESET = 1'b1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      noise = 1'b0;
      base  = NEVER;
      plan();
      #20 NSYSRESET = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_async: got %b, required %b", obs, {(2*N+5){1'b0}});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %b, required %b", i, obs, {(2*N+5){1'b0}});
         end
      end
   endtask

   task automatic test_nominal();
      int first [N+1];
      hold_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      for (int k = 0; k <= N; k++) first[k] = -1;
      start_seq();
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL nominal edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
         for (int k = 0; k < N; k++)
            if (sif.rst_n_o[k] === 1'b1 && first[k] < 0) first[k] = ecount;
         if (sif.seq_done === 1'b1 && first[N] < 0) first[N] = ecount;
      end
      for (int k = 0; k <= N; k++) begin
         checks++;
         if (first[k] != 12 + 4 * k) begin
            errors++;
            $display("FAIL nominal_release_edge[%0d]: got %0d, required %0d", k, first[k], 12 + 4 * k);
         end
      end
   endtask

   task automatic test_slow_ack();
      int first2;
      hold_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      rdy_edge[1] = 26;
      first2      = -1;
      start_seq();
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL slow_ack edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
         if (sif.rst_n_o[2] === 1'b1 && first2 < 0) first2 = ecount;
      end
      checks++;
      if (first2 != 26 || sif.timeout_err !== 4'b0000) begin
         errors++;
         $display("FAIL slow_ack_release: got edge %0d err %b, required edge 26 err 0000", first2, sif.timeout_err);
      end
   endtask

   task automatic test_timeout();
      hold_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      rdy_edge[2] = NEVER;
      start_seq();
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL timeout edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
         if (ecount == 51 || ecount == 52) begin
            checks++;
            if (sif.timeout_err !== ((ecount == 52) ? 4'b0100 : 4'b0000) ||
                sif.rst_n_o[3] !== ((ecount == 52) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL timeout_boundary edge %0d: got err %b rst3 %b", ecount, sif.timeout_err, sif.rst_n_o[3]);
            end
         end
      end
      checks++;
      if (sif.seq_done !== 1'b1 || sif.timeout_err !== 4'b0100) begin
         errors++;
         $display("FAIL timeout_final: got done %b err %b, required 1 0100", sif.seq_done, sif.timeout_err);
      end
   endtask

   task automatic test_midseq_reset();
      hold_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      rdy_edge[0] = NEVER;
      start_seq();
      for (int i = 0; i < 50; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL midseq_pre edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
      end
      checks++;
      if (sif.cur_ch !== 4'd2 || sif.timeout_err !== 4'b0001) begin
         errors++;
         $display("FAIL midseq_state: got cur_ch %0d err %b, required 2 0001", sif.cur_ch, sif.timeout_err);
      end
      #5 NSYSRESET = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL midseq_async: got %b, required %b", obs, {(2*N+5){1'b0}});
      end
      hold_reset();
      rdy_edge[0] = 0;
      start_seq();
      for (int i = 0; i < 32; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL midseq_restart edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         hold_reset();
         for (int k = 0; k < N; k++)
            rdy_edge[k] = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(0, 90));
         start_seq();
         noise = 1'b1;
         while (ecount < rel[N] + 8) begin
            tick();
            checks++;
            if (obs !== exp_vec(ecount)) begin
               errors++;
               $display("FAIL random[%0d] edge %0d: got %b, required %b", it, ecount, obs, exp_vec(ecount));
            end
         end
      end
      noise = 1'b0;
   endtask

`ifdef RESET_SEQ_SWREQ_EN
   task automatic test_swreq_run();
      int s;
      hold_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      rdy_edge[0] = NEVER;
      start_seq();
      repeat (60) tick();
      checks++;
      if (sif.seq_done !== 1'b1 || sif.timeout_err !== 4'b0001) begin
         errors++;
         $display("FAIL swreq_run_pre: got done %b err %b, required 1 0001", sif.seq_done, sif.timeout_err);
      end
      rdy_edge[0]    = 0;
      sif.sw_rst_req = 1'b1;
      tick();
      sif.sw_rst_req = 1'b0;
      s    = ecount;
      base = s;
      plan();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL swreq_run edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
         if (ecount == s + 9 || ecount == s + 10) begin
            checks++;
            if (sif.rst_n_o[0] !== ((ecount == s + 10) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL swreq_run_release edge +%0d: got %b", ecount - s, sif.rst_n_o[0]);
            end
         end
         tick();
      end
   endtask

   task automatic test_swreq_advance();
      hold_reset();
      for (int k = 0; k < N; k++) rdy_edge[k] = 0;
      start_seq();
      repeat (15) tick();
      sif.sw_rst_req = 1'b1;
      tick();
      sif.sw_rst_req = 1'b0;
      checks++;
      if (sif.cur_ch !== 4'd0 || sif.rst_n_o !== 4'b0000) begin
         errors++;
         $display("FAIL swreq_advance: got cur_ch %0d rst_n_o %b, required 0 0000", sif.cur_ch, sif.rst_n_o);
      end
      base = ecount;
      plan();
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec(ecount)) begin
            errors++;
            $display("FAIL swreq_advance edge %0d: got %b, required %b", ecount, obs, exp_vec(ecount));
         end
      end
   endtask
`endif

   initial begin
      sif.ch_ready = '0;
`ifdef RESET_SEQ_SWREQ_EN
      sif.sw_rst_req = 1'b0;
`endif
      ecount = 0;
      noise  = 1'b0;
      test_reset();
      test_nominal();
      test_slow_ack();
      test_timeout();
      test_midseq_reset();
      test_random();
`ifdef RESET_SEQ_SWREQ_EN
      test_swreq_run();
      test_swreq_advance();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
